// File: rtl/dtree_pkg.sv
// Shared types and width helpers for the sequential decision-tree evaluator.
package dtree_pkg;

  function automatic int addr_w(input int n_nodes);
    return (n_nodes <= 2) ? 1 : $clog2(n_nodes);
  endfunction

  function automatic int fidx_w(input int n_feat);
    return (n_feat <= 2) ? 1 : $clog2(n_feat);
  endfunction

  function automatic int node_w(input int n_feat, input int feat_w, input int n_nodes);
    return 1 + fidx_w(n_feat) + feat_w + 2 * addr_w(n_nodes);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WALK,
    ST_DONE
  } state_t;

  // Node layout at default parameters; field order matches the RTL slicing, MSB first.
  localparam int DEF_ADDR_W = addr_w(32);
  localparam int DEF_FIDX_W = fidx_w(16);
  localparam int DEF_FEAT_W = 8;

  typedef struct packed {
    logic                  is_leaf;
    logic [DEF_FIDX_W-1:0] feat_idx;
    logic [DEF_FEAT_W-1:0] threshold;
    logic [DEF_ADDR_W-1:0] left;
    logic [DEF_ADDR_W-1:0] right;
  } node_t;

endpackage

// File: rtl/dtree_node_mem.sv
// Register-file node table: one synchronous write port, one asynchronous read port.
module dtree_node_mem #(
  parameter int N_NODES = 32,
  parameter int ADDR_W  = 5,
  parameter int NODE_W  = 23
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [NODE_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [NODE_W-1:0] rdata
);

  logic [NODE_W-1:0] mem [N_NODES];

  // No reset: table contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < N_NODES)) mem[waddr] <= wdata;
  end

  assign rdata = (int'(raddr) < N_NODES) ? mem[raddr] : '0;

endmodule

// File: rtl/dtree_seq_eval.sv
// Sequential decision-tree evaluator: walks one node per cycle from the root to a leaf.
//   state | meaning
//   IDLE  | ready for a feature vector and node-table writes
//   WALK  | evaluating the node at cur, one per cycle
//   DONE  | result presented until out_ready
module dtree_seq_eval
  import dtree_pkg::*;
#(
  parameter  int N_FEAT    = 16,
  parameter  int FEAT_W    = 8,
  parameter  int CLASS_W   = 4,
  parameter  int N_NODES   = 32,
  parameter  int MAX_DEPTH = 15,
  localparam int ADDR_W    = addr_w(N_NODES),
  localparam int FIDX_W    = fidx_w(N_FEAT),
  localparam int NODE_W    = node_w(N_FEAT, FEAT_W, N_NODES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err,
  input  logic                     cfg_we,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [NODE_W-1:0]        cfg_wdata,
  output logic                     cfg_ready
);

  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  state_t                   state, state_nxt;
  logic [ADDR_W-1:0]        cur, cur_nxt;
  logic [DEPTH_W-1:0]       depth, depth_nxt;
  logic [N_FEAT*FEAT_W-1:0] feat_q, feat_nxt;
  logic [CLASS_W-1:0]       cls_q, cls_nxt;
  logic                     err_q, err_nxt;

  logic [NODE_W-1:0] node;
  logic              is_leaf;
  logic [FIDX_W-1:0] fidx;
  logic [FEAT_W-1:0] thr, feat_sel;
  logic [ADDR_W-1:0] left, right, child;
  logic              fidx_bad, child_bad;

  dtree_node_mem #(
    .N_NODES(N_NODES),
    .ADDR_W (ADDR_W),
    .NODE_W (NODE_W)
  ) u_mem (
    .clk  (clk),
    .we   (cfg_we && cfg_ready),
    .waddr(cfg_addr),
    .wdata(cfg_wdata),
    .raddr(cur),
    .rdata(node)
  );

  assign is_leaf = node[NODE_W-1];
  assign fidx    = node[2*ADDR_W+FEAT_W +: FIDX_W];
  assign thr     = node[2*ADDR_W +: FEAT_W];
  assign left    = node[ADDR_W +: ADDR_W];
  assign right   = node[0 +: ADDR_W];

  always_comb begin
    feat_sel = '0;
    for (int k = 0; k < N_FEAT; k++) begin
      if (int'(fidx) == k) feat_sel = feat_q[k*FEAT_W +: FEAT_W];
    end
  end

  assign fidx_bad  = int'(fidx) >= N_FEAT;
  assign child     = (feat_sel <= thr) ? left : right;
  assign child_bad = int'(child) >= N_NODES;

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    depth_nxt = depth;
    feat_nxt  = feat_q;
    cls_nxt   = cls_q;
    err_nxt   = err_q;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          feat_nxt  = in_feat;
          cur_nxt   = '0;
          depth_nxt = '0;
          state_nxt = ST_WALK;
        end
      end
      ST_WALK: begin
        if (is_leaf) begin
          cls_nxt   = thr[CLASS_W-1:0];
          err_nxt   = 1'b0;
          state_nxt = ST_DONE;
        end else if ((depth == DEPTH_W'(MAX_DEPTH)) || fidx_bad || child_bad) begin
          cls_nxt   = '0;
          err_nxt   = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          cur_nxt   = child;
          depth_nxt = depth + DEPTH_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cur    <= '0;
      depth  <= '0;
      feat_q <= '0;
      cls_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cur    <= cur_nxt;
      depth  <= depth_nxt;
      feat_q <= feat_nxt;
      cls_q  <= cls_nxt;
      err_q  <= err_nxt;
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign cfg_ready = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_class = cls_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_dtree_seq_eval.sv
// Directed and randomized-tree bench for dtree_seq_eval at default parameters.
module tb_dtree_seq_eval;
  import dtree_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_feat = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [3:0]   out_class;
  logic         out_err;
  logic         cfg_we = 1'b0;
  logic [4:0]   cfg_addr = '0;
  logic [22:0]  cfg_wdata = '0;
  logic         cfg_ready;

  int tests = 0;
  int fails = 0;
  node_t tbl [32];

  always #5 clk = ~clk;

  dtree_seq_eval dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_err(out_err),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic node_t mk_int(input int fi, input int th, input int l, input int r);
    node_t n;
    n.is_leaf = 1'b0; n.feat_idx = fi[3:0]; n.threshold = th[7:0];
    n.left = l[4:0]; n.right = r[4:0];
    return n;
  endfunction

  function automatic node_t mk_leaf(input int c);
    node_t n;
    n = '0;
    n.is_leaf = 1'b1; n.threshold = {4'h0, c[3:0]};
    return n;
  endfunction

  function automatic logic [127:0] feat2(input int v);
    logic [127:0] f;
    f = '0;
    f[23:16] = v[7:0];
    return f;
  endfunction

  function automatic void ref_eval(input logic [127:0] f, output logic [3:0] c, output logic e);
    int cur;
    cur = 0; c = '0; e = 1'b1;
    for (int d = 0; d <= 15; d++) begin
      node_t n;
      n = tbl[cur];
      if (n.is_leaf) begin c = n.threshold[3:0]; e = 1'b0; return; end
      if (d == 15) return;
      if (f[int'(n.feat_idx)*8 +: 8] <= n.threshold) cur = int'(n.left);
      else cur = int'(n.right);
    end
  endfunction

  task automatic write_node(input int a, input node_t n);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a[4:0]; cfg_wdata = n;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    tbl[a] = n;
  endtask

  task automatic load_small();
    write_node(0, mk_int(2, 127, 1, 2));
    write_node(1, mk_leaf(5));
    write_node(2, mk_leaf(9));
  endtask

  // mode 0: ready at once, 1: random backpressure, 2: hold 10 cycles with dropped cfg writes
  task automatic infer(input logic [127:0] f, input int mode, input bit wr, input int waddr,
                       input node_t wnode, output logic [3:0] cls, output logic err, output int lat);
    bit fired;
    int n;
    @(negedge clk);
    in_feat = f; in_valid = 1'b1;
    if (wr) begin
      cfg_we = 1'b1; cfg_addr = waddr[4:0]; cfg_wdata = wnode; tbl[waddr] = wnode;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    cls = out_class; err = out_err;
    if (!out_valid) begin
      chk("timeout", 32'(out_valid), 1);
      return;
    end
    if (mode == 2) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        out_ready = 1'b0; cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = mk_leaf(7);
        @(posedge clk); #1;
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_class", 32'(out_class), 32'(cls));
        chk("hold_in_ready", 32'(in_ready), 0);
      end
    end
    n = 0;
    do begin
      @(negedge clk);
      cfg_we = 1'b0;
      out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      fired = out_ready;
      #1;
      n++;
    end while (!fired && n < 50);
    out_ready = 1'b0;
  endtask

  task automatic gen_tree();
    int qn[$], qd[$];
    int nxt, nd, dd;
    node_t t [32];
    for (int i = 0; i < 32; i++) t[i] = mk_leaf(int'($urandom_range(0, 15)));
    nxt = 1;
    qn.push_back(0); qd.push_back(0);
    while (qn.size() > 0) begin
      nd = qn.pop_front(); dd = qd.pop_front();
      if (dd >= 7 || nxt + 2 > 32 || (nd != 0 && $urandom_range(0, 3) == 0)) begin
        t[nd] = mk_leaf(int'($urandom_range(0, 15)));
      end else begin
        t[nd] = mk_int(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), nxt, nxt + 1);
        qn.push_back(nxt);     qd.push_back(dd + 1);
        qn.push_back(nxt + 1); qd.push_back(dd + 1);
        nxt += 2;
      end
    end
    for (int i = 0; i < 32; i++) write_node(i, t[i]);
  endtask

  initial begin
    logic [3:0] c, ec;
    logic e, ee;
    int lat;
    bit seen;
    logic [127:0] f;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_class", 32'(out_class), 0);
    chk("rst_out_err", 32'(out_err), 0);
    rst_n = 1'b1;

    load_small();
    infer(feat2(127), 0, 0, 0, '0, c, e, lat);
    chk("small127_class", 32'(c), 5);
    chk("small127_err", 32'(e), 0);
    chk("small127_lat", 32'(lat), 3);
    infer(feat2(128), 0, 0, 0, '0, c, e, lat);
    chk("small128_class", 32'(c), 9);
    chk("small128_lat", 32'(lat), 3);
    infer(feat2(0), 0, 0, 0, '0, c, e, lat);
    chk("small0_class", 32'(c), 5);
    infer(feat2(255), 0, 0, 0, '0, c, e, lat);
    chk("small255_class", 32'(c), 9);

    // root rewritten as a leaf on the same edge the vector is accepted
    infer(feat2(128), 0, 1, 0, mk_leaf(3), c, e, lat);
    chk("rootleaf_class", 32'(c), 3);
    chk("rootleaf_err", 32'(e), 0);
    chk("rootleaf_lat", 32'(lat), 2);

    write_node(0, mk_int(0, 0, 0, 0));
    infer(feat2(0), 0, 0, 0, '0, c, e, lat);
    chk("loop_err", 32'(e), 1);
    chk("loop_class", 32'(c), 0);
    chk("loop_lat", 32'(lat), 17);

    load_small();
    infer(feat2(128), 2, 0, 0, '0, c, e, lat);
    chk("hold_result", 32'(c), 9);
    infer(feat2(128), 0, 0, 0, '0, c, e, lat);
    chk("readback_class", 32'(c), 9);
    chk("readback_lat", 32'(lat), 3);

    @(negedge clk);
    in_feat = feat2(127); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_out_valid", 32'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_valid", 32'(seen), 0);
    infer(feat2(127), 0, 0, 0, '0, c, e, lat);
    chk("midrst_next_class", 32'(c), 5);

    for (int t = 0; t < 4; t++) begin
      gen_tree();
      for (int v = 0; v < 250; v++) begin
        f = {$urandom, $urandom, $urandom, $urandom};
        ref_eval(f, ec, ee);
        infer(f, 1, 0, 0, '0, c, e, lat);
        chk("rand_class", 32'(c), 32'(ec));
        chk("rand_err", 32'(e), 32'(ee));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dtree_seq_eval.md
DTREE_SEQ_EVAL -- requirements
Module: dtree_seq_eval

Interface
REQ-001 SHALL have parameter N_FEAT, default 16, the number of input features.
REQ-002 SHALL have parameter FEAT_W, default 8, the width in bits of each feature and each threshold.
REQ-003 SHALL have parameter CLASS_W, default 4, the width of the class label.
REQ-004 SHALL have parameter N_NODES, default 32, the node table depth; ADDR_W = clog2(N_NODES).
REQ-005 SHALL have parameter MAX_DEPTH, default 15, the limit on comparisons per inference.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port in_valid/in_ready, input/output, 1 bit each: feature-vector handshake.
REQ-009 SHALL have port in_feat, input, N_FEAT*FEAT_W bits: feature k occupies bits [k*FEAT_W +: FEAT_W].
REQ-010 SHALL have port out_valid/out_ready, output/input, 1 bit each: result handshake.
REQ-011 SHALL have port out_class, output, CLASS_W bits: predicted class.
REQ-012 SHALL have port out_err, output, 1 bit: depth-limit or bad-address abort.
REQ-013 SHALL have ports cfg_we (in, 1), cfg_addr (in, ADDR_W) and cfg_wdata (in, NODE_W): node-table write.
REQ-014 SHALL have port cfg_ready, output, 1 bit: high only in IDLE.

Function
REQ-015 Node word fields: is_leaf(1), feat_idx(clog2 N_FEAT), threshold(FEAT_W), left(ADDR_W), right(ADDR_W); a leaf places its class in the low CLASS_W bits of threshold.
REQ-016 FSM states: IDLE, WALK, DONE.
REQ-017 IDLE: in_ready=1; on in_valid&&in_ready, latch in_feat, set cur=0, depth=0, go to WALK.
REQ-018 WALK processes exactly one node per cycle, reading the node table combinationally at cur.
REQ-019 Internal node: if feature[feat_idx] <= threshold (unsigned, inclusive) then cur=left, else cur=right; depth increments.
REQ-020 Leaf: out_class=class field, out_err=0, go to DONE.
REQ-021 If depth reaches MAX_DEPTH at a non-leaf, or if feat_idx >= N_FEAT or the child address is >= N_NODES: out_class=0, out_err=1, go to DONE.
REQ-022 Latency: a leaf at depth d gives out_valid exactly d+2 cycles after the accepting edge (root leaf: 2).
REQ-023 DONE: out_valid=1, with out_class and out_err held stable until out_valid&&out_ready, then return to IDLE.
REQ-024 in_ready=0 in WALK and DONE, so there is no back-to-back overlap and throughput is one inference per (d+3) cycles minimum.
REQ-025 A cfg_we write is applied only when cfg_ready=1; writes in WALK/DONE are dropped silently.
REQ-026 If cfg_we and in_valid coincide in IDLE, the write is applied and the vector is accepted on the same edge; the walk uses the updated table.
REQ-027 Node table contents are unaffected by rst_n.

Reset
REQ-028 With rst_n=0 at a clk edge: state=IDLE, out_valid=0, out_class=0, out_err=0, cur=0, depth=0; in_ready=1 and cfg_ready=1 in the first cycle after reset.
REQ-029 Reset asserted mid-WALK or in DONE aborts the inference with no out_valid pulse.

Structure
REQ-030 Package dtree_pkg SHALL hold the node struct typedef, the field-width functions, and the FSM state enum.
REQ-031 One sub-module, dtree_node_mem (register-file node table: one write port, one asynchronous read port), SHALL be instantiated.
REQ-032 The implementation SHALL use registers only, with no vendor RAM macros.

Verification
REQ-033 Load a 3-node tree (root: feat 2 <= 127 -> leaf class 5, else leaf class 9); feature2=127 -> out_class=5 after 3 cycles; feature2=128 -> 9.
REQ-034 Root is a leaf with class 3 -> out_valid 2 cycles after accept, out_class=3, out_err=0.
REQ-035 Self-looping node (left=right=0, non-leaf) with MAX_DEPTH=15 -> out_err=1, out_class=0 after 17 cycles.
REQ-036 Hold out_ready=0 for 10 cycles in DONE -> out_valid, out_class and in_ready=0 are stable; cfg_we during this time does not change the table (verify by readback inference).
REQ-037 Pulse rst_n=0 for 1 cycle mid-WALK -> no out_valid, IDLE the next cycle, and the table is intact (the next inference is correct).
REQ-038 Random 8-level trees vs. a reference model, 1000 vectors with random out_ready backpressure -> every class matches.
